// File: rtl/ledger_pkg.sv
// ledger_pkg: shared widths and record types for the ledger ingress gate.
// The struct types describe the default-width transaction and scoreboard
// records exchanged with the ledger core.
package ledger_pkg;

   localparam int USER_WIDTH_DEF    = 10;
   localparam int BALANCE_WIDTH_DEF = 64;

   typedef struct packed {
      logic [USER_WIDTH_DEF-1:0]    payer;
      logic [USER_WIDTH_DEF-1:0]    payee;
      logic [BALANCE_WIDTH_DEF-1:0] amount;
   } ledger_tx_t;

   typedef struct packed {
      logic                      v;
      logic [USER_WIDTH_DEF-1:0] payer;
      logic [USER_WIDTH_DEF-1:0] payee;
   } ledger_sb_slot_t;

endpackage

// File: rtl/ledger_issue_gate_if.sv
// ledger_issue_gate_if: request ingress handshake plus the issue port that
// drives the ledger core. The slave modport is the gate's view; the master
// modport is the view of whoever feeds requests and observes issues.
import ledger_pkg::*;

interface ledger_issue_gate_if #(
   parameter int USER_WIDTH    = USER_WIDTH_DEF,
   parameter int BALANCE_WIDTH = BALANCE_WIDTH_DEF
);
   logic                     in_valid;
   logic                     in_ready;
   logic [USER_WIDTH-1:0]    in_payer;
   logic [USER_WIDTH-1:0]    in_payee;
   logic [BALANCE_WIDTH-1:0] in_amount;

   logic                     out_valid;
   logic [USER_WIDTH-1:0]    out_payer;
   logic [USER_WIDTH-1:0]    out_payee;
   logic [BALANCE_WIDTH-1:0] out_amount;

   modport master (
      output in_valid, in_payer, in_payee, in_amount,
      input  in_ready, out_valid, out_payer, out_payee, out_amount
   );

   modport slave (
      input  in_valid, in_payer, in_payee, in_amount,
      output in_ready, out_valid, out_payer, out_payee, out_amount
   );
endinterface

// File: rtl/ledger_sync_fifo.sv
// ledger_sync_fifo: in-order synchronous FIFO with a combinational head read.
// DEPTH must be a power of two so the pointers wrap naturally.
module ledger_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] headData_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d;
   logic [AW-1:0]    rdPtr_q, rdPtr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign full_o     = (count_q == CW'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign headData_o = mem_q[rdPtr_q];
   assign doPush     = push_i & ~full_o;
   assign doPop      = pop_i & ~empty_o;

   // Pointer and occupancy updates; a simultaneous push and pop keeps the count.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      case ({doPush, doPop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= pushData_i;
   end

   // Control state register with synchronous reset emptying the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ledger_issue_gate.sv
// ledger_issue_gate: buffers transfer requests and issues them in order to
// the ledger core, holding back any head whose accounts overlap a recently
// issued transaction so the core never sees a read-after-write hazard.
// Optional statistics counters are built when LEDGER_GATE_STATS_EN is defined.
module ledger_issue_gate
   import ledger_pkg::*;
#(
   parameter int USER_WIDTH    = USER_WIDTH_DEF,
   parameter int BALANCE_WIDTH = BALANCE_WIDTH_DEF,
   parameter int FIFO_DEPTH    = 8,
   parameter int HAZARD_DEPTH  = 1,
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   ledger_issue_gate_if.slave   bus,
   output logic [CNT_W-1:0]     fifo_count,
   output logic                 hazard_stall
`ifdef LEDGER_GATE_STATS_EN
   ,
   output logic [31:0]          stat_issued,
   output logic [31:0]          stat_hazard_stalls
`endif
);

   typedef struct packed {
      logic [USER_WIDTH-1:0]    payer;
      logic [USER_WIDTH-1:0]    payee;
      logic [BALANCE_WIDTH-1:0] amount;
   } txT;

   typedef struct packed {
      logic                  v;
      logic [USER_WIDTH-1:0] payer;
      logic [USER_WIDTH-1:0] payee;
   } slotT;

   txT                      pushTx;
   txT                      headTx;
   logic                    push;
   logic                    fifoFull;
   logic                    fifoEmpty;
   logic                    anyHit;
   logic                    issue;

   slotT [HAZARD_DEPTH-1:0] sb_q, sb_d;
   logic                    outValid_q, outValid_d;
   txT                      outTx_q, outTx_d;
   logic                    hazardStall_q, hazardStall_d;

   assign pushTx         = '{payer: bus.in_payer, payee: bus.in_payee, amount: bus.in_amount};
   assign bus.in_ready   = ~fifoFull;
   assign push           = bus.in_valid & ~fifoFull;

   ledger_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(txT))
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .pushData_i (pushTx),
      .pop_i      (issue),
      .headData_o (headTx),
      .count_o    (fifo_count),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty)
   );

   // Compare the head's two accounts against both accounts of every live slot.
   always_comb begin
      anyHit = 1'b0;
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
         if (sb_q[i].v &&
             ((headTx.payer == sb_q[i].payer) || (headTx.payer == sb_q[i].payee) ||
              (headTx.payee == sb_q[i].payer) || (headTx.payee == sb_q[i].payee))) begin
            anyHit = 1'b1;
         end
      end
      issue = ~fifoEmpty & ~anyHit;
   end

   // Next state for the scoreboard shift register and the issue-port registers.
   always_comb begin
      sb_d          = '0;
      sb_d[0]       = issue ? '{v: 1'b1, payer: headTx.payer, payee: headTx.payee} : '0;
      for (int i = 1; i < HAZARD_DEPTH; i++) begin
         sb_d[i] = sb_q[i-1];
      end
      outValid_d    = issue;
      outTx_d       = issue ? headTx : outTx_q;
      hazardStall_d = ~fifoEmpty & anyHit;
   end

   // Registered state with synchronous reset clearing issues and scoreboard.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_q          <= '0;
         outValid_q    <= 1'b0;
         outTx_q       <= '0;
         hazardStall_q <= 1'b0;
      end else begin
         sb_q          <= sb_d;
         outValid_q    <= outValid_d;
         outTx_q       <= outTx_d;
         hazardStall_q <= hazardStall_d;
      end
   end

   assign bus.out_valid  = outValid_q;
   assign bus.out_payer  = outTx_q.payer;
   assign bus.out_payee  = outTx_q.payee;
   assign bus.out_amount = outTx_q.amount;
   assign hazard_stall   = hazardStall_q;

`ifdef LEDGER_GATE_STATS_EN
   logic [31:0] statIssued_q;
   logic [31:0] statStalls_q;

   // Saturating event counters; the stall count advances on the edge that sets hazard_stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         statIssued_q <= '0;
         statStalls_q <= '0;
      end else begin
         if (issue && (statIssued_q != '1))         statIssued_q <= statIssued_q + 32'd1;
         if (hazardStall_d && (statStalls_q != '1)) statStalls_q <= statStalls_q + 32'd1;
      end
   end

   assign stat_issued        = statIssued_q;
   assign stat_hazard_stalls = statStalls_q;
`endif

endmodule

// File: tb/tb_ledger_issue_gate.sv
// tb_ledger_issue_gate: directed self-checking bench for ledger_issue_gate.
// Inputs are driven and outputs sampled on the falling clock edge.
import ledger_pkg::*;

module tb_ledger_issue_gate;

   logic        clk;
   logic        rst;
   logic [3:0]  fifo_count;
   logic        hazard_stall;
`ifdef LEDGER_GATE_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_hazard_stalls;
`endif

   int assertCount = 0;
   int failCount   = 0;

   ledger_issue_gate_if #(.USER_WIDTH(10), .BALANCE_WIDTH(64)) bus ();

   ledger_issue_gate #(
      .USER_WIDTH    (10),
      .BALANCE_WIDTH (64),
      .FIFO_DEPTH    (8),
      .HAZARD_DEPTH  (1)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .bus                (bus),
      .fifo_count         (fifo_count),
      .hazard_stall       (hazard_stall)
`ifdef LEDGER_GATE_STATS_EN
      ,
      .stat_issued        (stat_issued),
      .stat_hazard_stalls (stat_hazard_stalls)
`endif
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic ledger_tx_t mkTx(input int payer, input int payee, input longint amount);
      ledger_tx_t t;
      t.payer  = payer[9:0];
      t.payee  = payee[9:0];
      t.amount = amount;
      return t;
   endfunction

   task automatic applyStimulus(input logic v, input ledger_tx_t t);
      bus.in_valid  = v;
      bus.in_payer  = t.payer;
      bus.in_payee  = t.payee;
      bus.in_amount = t.amount;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkIssue(input string tag, input int payer, input int payee, input longint amount);
      checkOutput({tag, "_valid"},  {63'd0, bus.out_valid}, 64'd1);
      checkOutput({tag, "_payer"},  {54'd0, bus.out_payer}, 64'(payer));
      checkOutput({tag, "_payee"},  {54'd0, bus.out_payee}, 64'(payee));
      checkOutput({tag, "_amount"}, bus.out_amount, 64'(amount));
   endtask

   // Directed sequence covering reset, latency, hazards, back-pressure and mid-run reset.
   initial begin
      int     modelCount;
      int     expIssued;
      int     sent;
      bit     sawFull;
      logic   pushing;
      logic   expectIssue;

      rst = 1'b1;
      applyStimulus(1'b0, mkTx(0, 0, 0));
      @(negedge clk);
      step();
      step();
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_out_valid",    {63'd0, bus.out_valid}, 64'd0);
      checkOutput("rst_out_payer",    {54'd0, bus.out_payer}, 64'd0);
      checkOutput("rst_out_amount",   bus.out_amount, 64'd0);
      checkOutput("rst_fifo_count",   {60'd0, fifo_count}, 64'd0);
      checkOutput("rst_hazard_stall", {63'd0, hazard_stall}, 64'd0);
      checkOutput("rst_in_ready",     {63'd0, bus.in_ready}, 64'd1);

      $display("[TB] single request 3->7");
      applyStimulus(1'b1, mkTx(3, 7, 100));
      step();
      checkOutput("single_count_after_push", {60'd0, fifo_count}, 64'd1);
      checkOutput("single_not_yet_valid", {63'd0, bus.out_valid}, 64'd0);
      applyStimulus(1'b0, mkTx(0, 0, 0));
      step();
      checkIssue("single_issue", 3, 7, 100);
      checkOutput("single_count_drained", {60'd0, fifo_count}, 64'd0);
      step();
      checkOutput("single_one_cycle", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("single_hold_payer", {54'd0, bus.out_payer}, 64'd3);

      $display("[TB] conflicting back-to-back 1->2 then 2->5");
      applyStimulus(1'b1, mkTx(1, 2, 50));
      step();
      applyStimulus(1'b1, mkTx(2, 5, 10));
      step();
      checkIssue("conf_first", 1, 2, 50);
      checkOutput("conf_first_no_stall", {63'd0, hazard_stall}, 64'd0);
      applyStimulus(1'b0, mkTx(0, 0, 0));
      step();
      checkOutput("conf_bubble", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("conf_stall", {63'd0, hazard_stall}, 64'd1);
      step();
      checkIssue("conf_second", 2, 5, 10);
      checkOutput("conf_stall_cleared", {63'd0, hazard_stall}, 64'd0);
      checkOutput("conf_count_drained", {60'd0, fifo_count}, 64'd0);

      $display("[TB] non-conflicting back-to-back 1->2 then 3->4");
      applyStimulus(1'b1, mkTx(1, 2, 11));
      step();
      applyStimulus(1'b1, mkTx(3, 4, 22));
      step();
      checkIssue("nc_first", 1, 2, 11);
      applyStimulus(1'b0, mkTx(0, 0, 0));
      step();
      checkIssue("nc_second", 3, 4, 22);
      checkOutput("nc_no_stall", {63'd0, hazard_stall}, 64'd0);

      $display("[TB] burst of 16 with shared payer 5");
      modelCount = 0;
      expIssued  = 0;
      sent       = 0;
      sawFull    = 1'b0;
      for (int cyc = 1; cyc <= 32; cyc++) begin
         pushing = (sent < 16) && (modelCount < 8);
         if (pushing) applyStimulus(1'b1, mkTx(5, 100 + sent, 1000 + sent));
         else         applyStimulus(1'b0, mkTx(0, 0, 0));
         expectIssue = ((cyc % 2) == 0) && (expIssued < 16);
         step();
         if (pushing) begin
            sent++;
            modelCount++;
         end
         checkOutput("burst_out_valid", {63'd0, bus.out_valid}, {63'd0, expectIssue});
         if (expectIssue) begin
            modelCount--;
            checkOutput("burst_payer",  {54'd0, bus.out_payer}, 64'd5);
            checkOutput("burst_payee",  {54'd0, bus.out_payee}, 64'(100 + expIssued));
            checkOutput("burst_amount", bus.out_amount, 64'(1000 + expIssued));
            expIssued++;
         end
         if (modelCount == 8) sawFull = 1'b1;
         checkOutput("burst_count",    {60'd0, fifo_count}, 64'(modelCount));
         checkOutput("burst_in_ready", {63'd0, bus.in_ready}, {63'd0, (modelCount < 8)});
      end
      checkOutput("burst_all_issued", 64'(expIssued), 64'd16);
      checkOutput("burst_reached_full", {63'd0, sawFull}, 64'd1);

      $display("[TB] queue 4 conflicting entries then reset");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, mkTx(7, 20 + i, 300 + i));
         step();
      end
      applyStimulus(1'b0, mkTx(0, 0, 0));
      checkOutput("prerst_count", {60'd0, fifo_count}, 64'd4);
      checkOutput("prerst_stall", {63'd0, hazard_stall}, 64'd1);
`ifdef LEDGER_GATE_STATS_EN
      checkOutput("prerst_stat_issued", {32'd0, stat_issued}, 64'd24);
      checkOutput("prerst_stat_stalls", {32'd0, stat_hazard_stalls}, 64'd19);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("midrst_count",     {60'd0, fifo_count}, 64'd0);
      checkOutput("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("midrst_out_payer", {54'd0, bus.out_payer}, 64'd0);
      checkOutput("midrst_stall",     {63'd0, hazard_stall}, 64'd0);
`ifdef LEDGER_GATE_STATS_EN
      checkOutput("midrst_stat_issued", {32'd0, stat_issued}, 64'd0);
      checkOutput("midrst_stat_stalls", {32'd0, stat_hazard_stalls}, 64'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("midrst_no_stale_issue", {63'd0, bus.out_valid}, 64'd0);
      end
      applyStimulus(1'b1, mkTx(11, 12, 77));
      step();
      checkOutput("postrst_latency_wait", {63'd0, bus.out_valid}, 64'd0);
      applyStimulus(1'b0, mkTx(0, 0, 0));
      step();
      checkIssue("postrst_issue", 11, 12, 77);

      $display("[TB] self-transfer 9->9 then 9->1");
      applyStimulus(1'b1, mkTx(9, 9, 5));
      step();
      applyStimulus(1'b1, mkTx(9, 1, 5));
      step();
      checkIssue("self_first", 9, 9, 5);
      applyStimulus(1'b0, mkTx(0, 0, 0));
      step();
      checkOutput("self_bubble", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("self_stall",  {63'd0, hazard_stall}, 64'd1);
      step();
      checkIssue("self_second", 9, 1, 5);
`ifdef LEDGER_GATE_STATS_EN
      checkOutput("final_stat_issued", {32'd0, stat_issued}, 64'd3);
      checkOutput("final_stat_stalls", {32'd0, stat_hazard_stalls}, 64'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/ledger_issue_gate.md
# ledger_issue_gate

Ingress stage directly upstream of the ledger core: buffers incoming transfer requests in a small FIFO and issues them in order on the core's `s_valid/s_payer/s_payee/s_amount` request port. The core reads balances at issue and writes them back one cycle later without forwarding, so this gate holds back any head transaction whose accounts overlap a recently issued one. It guarantees the core never observes a read-after-write hazard.

## Interface
- `USER_WIDTH`, 10: account index width; must match the core.
- `BALANCE_WIDTH`, 64: amount width; must match the core.
- `FIFO_DEPTH`, 8: queue entries; power of two, ≥2.
- `HAZARD_DEPTH`, 1: number of most recent issue slots checked for conflicts; ≥1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: gate can accept; transfer occurs on `in_valid && in_ready`.
- `in_payer`, `in_payee` in USER_WIDTH each: accounts.
- `in_amount` in BALANCE_WIDTH: transfer amount.
- `out_valid` out 1: drives core `s_valid`; high for exactly one cycle per issued transaction.
- `out_payer`, `out_payee` out USER_WIDTH: drive core `s_payer`, `s_payee`.
- `out_amount` out BALANCE_WIDTH: drives core `s_amount`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `hazard_stall` out 1: the head was valid but blocked by a conflict this cycle.
- `stat_issued`, `stat_hazard_stalls` out 32 each: present only with `LEDGER_GATE_STATS_EN`.

## Operation
- The FIFO is in-order with head-of-line blocking. Entries are never reordered or dropped.
- `in_ready = (fifo_count < FIFO_DEPTH)`, derived from registered count only. It never depends on `in_valid`.
- Scoreboard: a shift register of HAZARD_DEPTH slots `{v, payer, payee}`.
  - Every cycle, slot0 receives the transaction issued at that edge, or `v=0` for a bubble.
  - The oldest slot is discarded.
- Conflict: the head is non-empty and, for any slot with `v=1`, head.payer or head.payee equals slot.payer or slot.payee. That is four comparisons per slot.
- Issue occurs when the head is non-empty and there is no conflict. At the next edge:
  - `out_*` are loaded with the head fields and `out_valid` is set to 1.
  - The head is popped.
  - Slot0 is loaded.
- Otherwise `out_valid` is 0 at the next edge and `out_payer/payee/amount` hold their previous values.
- `hazard_stall` is registered: it is 1 for the cycle after a conflict blocked a non-empty head, otherwise 0.
- Self-transfers (payer == payee) are issued normally and go through the conflict check like any other transaction.
- A push and a pop in the same edge leave the count unchanged. A push while full cannot occur because `in_ready` is 0.

## Timing
- Reset (sync, `rst`=1 at an edge) sets:
  - `out_valid`=0, `out_payer`=0, `out_payee`=0, `out_amount`=0.
  - `fifo_count`=0 and `hazard_stall`=0.
  - All scoreboard slots `v=0`.
  - Stats to 0.
- `in_ready` is 1 in the first cycle after reset.
- Reset mid-operation discards all queued entries and scoreboard contents. Nothing is issued afterwards until new pushes arrive.
- Latency: a request accepted at edge E appears on `out_*` with `out_valid`=1 at edge E+1 at the earliest, when the FIFO is empty and there is no conflict.
- Throughput: 1 issue per cycle for non-conflicting traffic.
  - With HAZARD_DEPTH=1, a conflicting successor issues at E+2 after a predecessor issued at E, giving exactly one bubble.
  - In general, the bubble count is HAZARD_DEPTH minus the number of intervening issue slots, with a minimum of 0.
- The FIFO fills only while issues are blocked by conflicts.

## Configuration
- `LEDGER_GATE_STATS_EN` defined:
  - `stat_issued` increments on each issue.
  - `stat_hazard_stalls` increments on each cycle `hazard_stall` is set.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and are cleared by `rst`.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- `ledger_pkg` holds:
  - `USER_WIDTH_DEF` and `BALANCE_WIDTH_DEF`.
  - `typedef struct packed {payer, payee, amount} ledger_tx_t`.
  - `typedef struct packed {v, payer, payee} ledger_sb_slot_t`.
- One sub-module, `ledger_sync_fifo`, parameterised by DEPTH and the data type/width. It provides push/pop, a combinational head read, count, full and empty.
- The scoreboard, conflict compare and output registers live in the top module.

## Test plan
- Single request (3→7, 100) accepted at edge E:
  - `out_valid`=1 at E+1 with 3/7/100, for exactly one cycle.
  - `fifo_count` returns to 0.
- Back-to-back (1→2, 50) then (2→5, 10):
  - The second request issues two edges after the first.
  - `hazard_stall`=1 for one cycle.
  - With stats enabled: `stat_issued`=2, `stat_hazard_stalls`=1.
- Back-to-back non-conflicting (1→2) then (3→4): consecutive `out_valid` cycles with no stall.
- 16 requests all with payer 5, pushed every cycle at FIFO_DEPTH=8:
  - Issues occur every other cycle.
  - `in_ready` drops when `fifo_count`=8.
  - All 16 come out in order with correct amounts, none lost.
- `rst` asserted for one cycle with 4 entries queued:
  - `fifo_count`=0 and `out_valid`=0 afterwards.
  - No stale issue follows.
  - The next pushed request issues with minimum latency.
- Self-transfer (9→9, 5) followed by (9→1, 5): both issue, the second after one bubble.
